// File: rtl/xpt_phase_sequencer.sv
// Execution-phase sequencer: owns the XPT phase counter, ITABLE sub-state and
// the CM1/CMR cycle mode, and gates the per-instruction decoders with enable.
module xpt_phase_sequencer #(
  parameter int unsigned XPT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       mem_ready,
  input  logic [7:0] itable_in,
  input  logic [7:0] itable_set,
  input  logic       reset_itable,
  input  logic       reset_xpt,
  input  logic       set_cm1,
  input  logic       set_cmr,
  output logic [3:0] XPT,
  output logic [3:0] notXPT,
  output logic [7:0] ITABLE,
  output logic [7:0] notITABLE,
  output logic       enable,
  output logic       CM1,
  output logic       CMR,
  output logic       xpt_fault
);

  localparam int unsigned XPT_W    = 4;
  localparam int unsigned ITABLE_W = 8;
  localparam logic [XPT_W-1:0] XPT_LAST = XPT_W'(XPT_MAX);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t state;

  logic [XPT_W-1:0]    xpt_inc;
  logic [ITABLE_W-1:0] itable_upd;

  // Candidate next values used during a ready EXEC cycle.
  always_comb begin
    xpt_inc    = XPT + XPT_W'(1);
    itable_upd = reset_itable ? itable_set : (ITABLE | itable_set);
  end

  // Decoders only see a live cycle while executing and the bus is ready.
  assign enable = (state == EXEC) && mem_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= FETCH;
      XPT       <= '0;
      notXPT    <= '1;
      ITABLE    <= '0;
      notITABLE <= '1;
      CM1       <= 1'b1;
      CMR       <= 1'b0;
      xpt_fault <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state     <= EXEC;
            ITABLE    <= itable_in;
            notITABLE <= ~itable_in;
            XPT       <= '0;
            notXPT    <= '1;
            CM1       <= 1'b0;
            CMR       <= 1'b0;
          end
        end
        EXEC: begin
          if (mem_ready) begin
            // Saturate at the last phase and flag it; sequencing carries on.
            if (reset_xpt) begin
              XPT    <= '0;
              notXPT <= '1;
            end else if (XPT == XPT_LAST) begin
              xpt_fault <= 1'b1;
            end else begin
              XPT    <= xpt_inc;
              notXPT <= ~xpt_inc;
            end

            ITABLE    <= itable_upd;
            notITABLE <= ~itable_upd;

            if (set_cm1) begin
              state <= FETCH;
              CM1   <= 1'b1;
              CMR   <= 1'b0;
            end else if (set_cmr) begin
              CM1   <= 1'b0;
              CMR   <= 1'b1;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
